// File: rtl/scale_acc_sched.sv
// Round-robin scheduler that runs one granted sample through scale, threshold-accumulate
// and output phases, returning the result with a per-requester completion pulse.
module scale_acc_sched #(
  parameter int unsigned   NREQ      = 4,
  parameter int unsigned   DW        = 32,
  parameter logic [15:0]   SCALE_Q8  = 16'd384,
  parameter logic [DW-1:0] THRESHOLD = DW'(2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      data_out,
  output logic               valid_out,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshake: a requester raises req and holds it until its done pulse; the job is
  // committed at the grant edge (data_in sampled there) and always runs to completion.

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALE  = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t            state;
  logic [IW-1:0]     last_winner;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand_idx;
  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [DW-1:0]     pick_data;
  logic [DW-1:0]     sample_r;
  logic [DW-1:0]     temp_r;
  logic [DW-1:0]     acc_r;
  logic [DW+15:0]    product;
  int                cand;

  assign state_dbg = state;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand     = (int'(last_winner) + k) % int'(NREQ);
      cand_idx = cand[IW-1:0];
      if (!pick_valid && req[cand_idx]) begin
        pick_valid  = 1'b1;
        pick_idx    = cand_idx;
      end
    end
    if (pick_valid) pick_onehot[pick_idx] = 1'b1;
    pick_data = data_in[int'(pick_idx)*int'(DW) +: DW];
  end

  assign product = {16'd0, sample_r} * {{DW{1'b0}}, SCALE_Q8};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= '0;
      valid_out   <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      sample_r    <= '0;
      temp_r      <= '0;
      acc_r       <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      done      <= '0;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sample_r    <= pick_data;
            grant       <= pick_onehot;
            last_winner <= pick_idx;
            busy        <= 1'b1;
            state       <= SCALE;
          end
        end
        SCALE: begin
          // Q8.8 multiply: drop the fractional byte, keep the low DW bits.
          temp_r <= product[DW+7:8];
          acc_r  <= {{(DW-8){1'b0}}, SCALE_Q8[15:8]};
          state  <= ACCUM;
        end
        ACCUM: begin
          if (temp_r > THRESHOLD) acc_r <= acc_r + temp_r;
          state <= OUTPUT;
        end
        OUTPUT: begin
          data_out  <= acc_r;
          valid_out <= 1'b1;
          done      <= grant;
          grant     <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_acc_sched.sv
// Bench for scale_acc_sched: directed scenarios from the job rules plus a randomized
// stream checked against a job-level reference model.
module tb_scale_acc_sched;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      data_out;
  logic               valid_out;
  logic               busy;
  logic [1:0]         state_dbg;

  int errors = 0;
  int checks = 0;

  // reference model: job phase counter, last winner, expected outputs
  int              m_phase;
  int              m_w;
  int              m_lw;
  logic [DW-1:0]   exp_q[$];
  logic [NREQ-1:0] e_grant;
  logic [NREQ-1:0] e_done;
  logic            e_valid;
  logic            e_busy;
  logic [DW-1:0]   e_data;

  scale_acc_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .done      (done),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] s);
    logic [63:0] p;
    logic [63:0] t;
    logic [63:0] a;
    p = 64'(s) * 64'd384;
    t = (p >> 8) & 64'h0000_0000_FFFF_FFFF;
    a = 64'd1 + ((t > 64'd2) ? t : 64'd0);
    return a[DW-1:0];
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_w     = 0;
    m_lw    = NREQ - 1;
    exp_q.delete();
    e_grant = '0;
    e_done  = '0;
    e_valid = 1'b0;
    e_busy  = 1'b0;
    e_data  = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d);
    e_done  = '0;
    e_valid = 1'b0;
    if (m_phase == 0) begin
      if (r != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_lw + k) % NREQ;
          if (r[c]) begin
            m_w = c;
            break;
          end
        end
        m_lw = m_w;
        exp_q.push_back(ref_result(d[m_w*DW +: DW]));
        e_grant      = '0;
        e_grant[m_w] = 1'b1;
        e_busy       = 1'b1;
        m_phase      = 1;
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else begin
      m_phase     = 0;
      e_grant     = '0;
      e_busy      = 1'b0;
      e_valid     = 1'b1;
      e_done      = '0;
      e_done[m_w] = 1'b1;
      e_data      = exp_q.pop_front();
    end
  endtask

  // one clock: inputs seen at the edge feed the model, outputs settle 1 time unit later
  task automatic tick();
    logic [NREQ-1:0]    r;
    logic [NREQ*DW-1:0] d;
    r = req;
    d = data_in;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    data_in[i*DW +: DW] = v;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = '0;
    data_in = '0;
    model_reset();
    #13;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_data(0, 32'd4);
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant_hold: got %b expected 0001", grant); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", valid_out); end
    tick();
    req = 4'b0000;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid_out); end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done); end
    checks++; if (data_out !== 32'd7) begin errors++; $display("FAIL single_data: got %0d expected 7", data_out); end
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
    tick();
    checks++; if (valid_out !== 1'b0 || done !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got valid=%b done=%b expected 0/0000", valid_out, done); end
  endtask

  task automatic test_threshold();
    logic [DW-1:0] din [4];
    logic [DW-1:0] dexp [4];
    din  = '{32'd1, 32'd2, 32'd0, 32'hFFFF_FFFF};
    dexp = '{32'd1, 32'd4, 32'd1, 32'h7FFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      set_data(0, din[i]);
      req = 4'b0001;
      tick(); tick(); tick(); tick();
      req = 4'b0000;
      checks++; if (valid_out !== 1'b1 || data_out !== dexp[i]) begin errors++; $display("FAIL threshold_%0d: got valid=%b data=%h expected 1/%h", i, valid_out, data_out, dexp[i]); end
      checks++; if (data_out !== e_data) begin errors++; $display("FAIL threshold_model_%0d: got %h expected %h", i, data_out, e_data); end
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < NREQ; i++) set_data(i, $urandom);
    req = 4'b1000;
    tick(); tick(); tick(); tick();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (grant !== order[k]) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, grant, order[k]); end
      tick(); tick(); tick();
      checks++; if (done !== order[k] || valid_out !== 1'b1) begin errors++; $display("FAIL rr_done_%0d: got done=%b valid=%b expected %b/1", k, done, valid_out, order[k]); end
      checks++; if (data_out !== e_data) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, data_out, e_data); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_job();
    set_data(2, $urandom);
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL drop_grant: got %b expected 0100", grant); end
    tick();
    req = 4'b0000;
    tick(); tick();
    checks++; if (done !== 4'b0100 || valid_out !== 1'b1) begin errors++; $display("FAIL drop_done: got done=%b valid=%b expected 0100/1", done, valid_out); end
    checks++; if (data_out !== e_data) begin errors++; $display("FAIL drop_data: got %h expected %h", data_out, e_data); end
    set_data(0, $urandom);
    set_data(1, $urandom_range(0, 3));
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL raise_grant0: got %b expected 0001", grant); end
    req = 4'b0011;
    tick(); tick(); tick();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL raise_done0: got %b expected 0001", done); end
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL raise_grant1: got %b expected 0010", grant); end
    tick(); tick(); tick();
    req = 4'b0000;
    checks++; if (done !== 4'b0010 || data_out !== e_data) begin errors++; $display("FAIL raise_done1: got done=%b data=%h expected 0010/%h", done, data_out, e_data); end
    tick();
  endtask

  task automatic test_async_reset();
    set_data(2, $urandom);
    req = 4'b0100;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (grant !== 4'b0000 || done !== 4'b0000) begin errors++; $display("FAIL areset_grant_done: got grant=%b done=%b expected 0000/0000", grant, done); end
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_valid_busy: got valid=%b busy=%b expected 0/0", valid_out, busy); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", data_out); end
    set_data(1, $urandom);
    req = 4'b0010;
    @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL areset_hold: got valid=%b grant=%b expected 0/0000", valid_out, grant); end
    #2 rst_n = 1'b1;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL areset_first_grant: got %b expected 0010", grant); end
    tick(); tick(); tick();
    req = 4'b0000;
    checks++; if (valid_out !== 1'b1 || done !== 4'b0010 || data_out !== e_data) begin errors++; $display("FAIL areset_job: got valid=%b done=%b data=%h expected 1/0010/%h", valid_out, done, data_out, e_data); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) set_data(i, $urandom);
        else set_data(i, DW'($urandom_range(0, 5)));
      end
      tick();
      checks++; if (grant !== e_grant) begin errors++; $display("FAIL rand_grant_%0d: got %b expected %b", n, grant, e_grant); end
      checks++; if (done !== e_done) begin errors++; $display("FAIL rand_done_%0d: got %b expected %b", n, done, e_done); end
      checks++; if (valid_out !== e_valid) begin errors++; $display("FAIL rand_valid_%0d: got %b expected %b", n, valid_out, e_valid); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy_%0d: got %b expected %b", n, busy, e_busy); end
      checks++; if (data_out !== e_data) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", n, data_out, e_data); end
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_threshold();
    test_round_robin();
    test_mid_job();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scale_acc_sched.md
# scale_acc_sched

Round-robin scheduler and sequencer for the shared scale/threshold/accumulate datapath. Up to NREQ requesters post 32-bit samples. The block grants one requester at a time and runs that sample through the fixed three-phase sequence: scale, threshold-accumulate, output. It returns the result on a shared output bus with a per-requester completion pulse, and sits between the requester ports and the scaling datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, sample/result width
- SCALE_Q8, 384, unsigned scale factor in Q8.8 (384 = 1.5); 16 bits
- THRESHOLD, 2, unsigned threshold on scaled value, DW bits
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request level
- data_in  input  NREQ*DW  requester i sample at bits [i*DW +: DW]
- grant  output  NREQ  one-hot grant, held for the whole job
- done  output  NREQ  one-cycle completion pulse to the granted requester
- data_out  output  DW  accumulated result, held until next job completes
- valid_out  output  1  one-cycle pulse, data_out updated
- busy  output  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, SCALE, ACCUM, OUTPUT.
- IDLE:
  - If any req bit is set, pick the winner by round-robin. Search starts at last_winner+1 and wraps modulo NREQ.
  - Latch data_in slice into sample_r, set grant one-hot, update last_winner, go to SCALE.
  - If no req bit is set, stay in IDLE.
- SCALE:
  - temp_r = low DW bits of ((sample_r * SCALE_Q8) >> 8). The product is DW+16 bits unsigned; the fractional part is truncated.
  - acc_r = SCALE_Q8 >> 8 (integer part, 1 by default).
  - Go to ACCUM.
- ACCUM:
  - If temp_r > THRESHOLD (unsigned, strict), acc_r = acc_r + temp_r, mod 2^DW. Otherwise acc_r is unchanged.
  - Go to OUTPUT.
- OUTPUT:
  - data_out = acc_r; valid_out and done[winner] pulse for one cycle.
  - grant clears; go to IDLE.
- Requester contract: hold req until done.
  - Deasserting req mid-job does not abort the job; it completes and pulses done.
  - data_in is sampled only at the IDLE grant edge.
- Only one grant bit is ever high. done is only ever asserted on the granted bit.

## Timing
- Reset (async, any state) sets:
  - state = IDLE
  - grant = 0, done = 0, valid_out = 0, busy = 0
  - data_out = 0, sample_r = 0, temp_r = 0, acc_r = 0
  - last_winner = NREQ-1, so requester 0 has first priority.
- Reset mid-job drops the job silently: no done, no valid_out.
- Edge E0 samples req in IDLE. The cycle after E0 has grant and busy high (state SCALE).
- E1 → ACCUM; E2 → OUTPUT.
- Edge E3 registers data_out. The cycle after E3 has valid_out=1 and done[w]=1, grant=0, busy=0.
- Latency is 4 cycles from req sampled to valid_out visible.
- The earliest next grant is edge E4. Maximum throughput is 1 job per 4 cycles.
- A requester still holding req after its done may be regranted at E4 only if no other requester is pending, by round-robin.
- All outputs are registered; no combinational path from req/data_in to any output.

## Test plan
- Single job: req[0]=1, data_in[0]=4 → grant=0001 for 3 cycles; then valid_out=1, done=0001, data_out=7 (temp 6 > 2, 1+6). Latency 4.
- Threshold boundary:
  - data=1 → temp 1, data_out=1.
  - data=2 → temp 3, data_out=4.
  - data=0 → data_out=1.
- Wrap/truncation: data=0xFFFFFFFF → temp=0x7FFFFFFE, data_out=0x7FFFFFFF.
- Round-robin fairness: req=1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001. Each job is 4 cycles apart, and each done matches its grant.
- Mid-job events:
  - req[2] dropped during ACCUM → done[2] still pulses.
  - req[1] raised during req[0]'s job → granted at E4 after req[0]'s done.
- Async reset asserted in ACCUM → all outputs 0 immediately, no valid_out. After release with req=0010, the first grant is 0010, and data_out is correct 4 cycles later.
